stream_window_gen: RTL and testbench
====================================

Name: stream_window_gen

Overview:
- Parametrised successor to the fixed 3x3 line buffers in the edge-detection pipeline.
- Takes a raster pixel stream with a valid/ready handshake and frame-start marking.
- Emits one WIN x WIN neighbourhood per input pixel position, with frame-boundary handling and end-of-frame flush.
- Drop-in front end for the Sobel, NMS and local-mean stages at any image size, data width or window size.

Parameters:
- DATA_W, 8: bits per pixel/tap.
- IMG_W, 256: pixels per row (≥ WIN).
- IMG_H, 256: rows per frame (≥ WIN).
- WIN, 3: window size; legal values are 3 or 5. Other values fail elaboration. R = (WIN-1)/2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat when in_valid && in_ready.
- in_data  in  DATA_W  pixel value.
- in_sof  in  1  qualifies the first pixel (0,0) of a frame.
- out_valid  out  1  window valid; one-cycle pulse, no backpressure.
- out_data  out  WIN*WIN*DATA_W  tap (r,c) at [(r*WIN+c)*DATA_W +: DATA_W]; r=0 is top row, c=0 is left column; centre tap is R*WIN+R.
- out_sof  out  1  with out_valid: window centred on (0,0).
- out_eol  out  1  with out_valid: centre column = IMG_W-1.
- out_eof  out  1  with out_valid: centre (IMG_W-1, IMG_H-1).
- busy  out  1  high from accepted SOF until the eof window is emitted.

Behaviour:
- Reset values: all outputs 0 except in_ready = 1. Counters cleared; FSM in IDLE. Line-RAM contents are don't-care.
- FSM IDLE: accepted beats without in_sof are dropped. An accepted beat with in_sof → RUN, and that beat is stored as pixel (0,0).
- FSM RUN:
  - Input column counter ix wraps at IMG_W-1 and increments row iy.
  - Accepted beat k = iy*IMG_W+ix is pushed into WIN-1 cascaded row delays (IMG_W deep) plus a WIN-wide shift register per row.
  - Output index j = k - (R*IMG_W+R) is emitted when j ≥ 0.
  - After the beat with k = IMG_W*IMG_H-1 → FLUSH.
- FSM FLUSH:
  - in_ready = 0.
  - Internally injects R*IMG_W+R phantom beats, one per cycle, with data = 0 (never visible because of clamping).
  - After the eof window → IDLE; in_ready returns to 1 the following cycle.
- Latency: out_valid rises exactly 1 cycle after the accepted/phantom beat that completes window j.
- Exactly IMG_W*IMG_H windows are emitted per frame, in raster order.
- Border handling, default replicate:
  - A tap at (cx+dc-R, cy+dr-R) is clamped to [0,IMG_W-1] x [0,IMG_H-1].
  - Selection uses the output column/row counters ox, oy and per-tap muxes; no wrap across rows.
- Input gaps (in_valid = 0) stall all state; no output is produced that cycle.
- in_sof accepted in RUN: abort the current frame without flushing, restart with this beat as (0,0), and clear output counters. Partial-frame windows already emitted remain emitted.
- in_sof accepted in IDLE on the same cycle FLUSH completes: not possible, because in_ready = 0 during FLUSH.
- Reset mid-frame: immediate return to IDLE; no further out_valid.
- Width rules: counters are $clog2(IMG_W) and $clog2(IMG_H) bits. Data is passed through unmodified.

Optional Feature:
- Macro: STREAM_WINDOW_BORDER_ZERO_EN.
- Defined: out-of-image taps are forced to 0 instead of replicated; in-image taps are unchanged.
- Undefined: replicate (clamp) as above.
- Timing and flags are identical in both builds.

Decomposition:
- Package stream_window_pkg:
  - MAX_WIN = 5.
  - State enum {IDLE, RUN, FLUSH}.
  - Function tap_lsb(r,c,win) returning the bit offset.
  - Function clamp_idx(base, off, limit).
- Sub-module line_delay_ram: single-port-read/single-write circular buffer, parameters DATA_W and DEPTH, advance enable, one-cycle delay per advance. Instantiated WIN-1 times.

Test Plan:
- IMG_W=4, IMG_H=3, WIN=3, in_data = k (0..11), in_valid always 1 from SOF:
  - First out_valid 1 cycle after beat k=5; out_sof = 1; taps row-major = 0,0,1, 0,0,1, 4,4,5.
- Same frame, window centre (1,1): taps = 0,1,2, 4,5,6, 8,9,10; out_eol = 0.
- Same frame, end of input: in_ready low for 5 cycles after k=11; 12 windows total.
  - Last window has out_eof = out_eol = 1; taps = 6,7,7, 10,11,11, 10,11,11.
  - in_ready high again the next cycle.
- Same stimulus with STREAM_WINDOW_BORDER_ZERO_EN: first window taps = 0,0,0, 0,0,1, 0,4,5.
- in_valid toggling 1/0 each cycle, WIN=5, IMG_W=8, IMG_H=6:
  - 48 windows, identical to the gap-free run, with no out_valid in gap cycles.
  - First window follows the beat k=2*8+2=18.
- in_sof reasserted at k=7 of frame 1 (4x3 config), then a full frame 2:
  - Windows restart with out_sof on the window centred at frame-2 (0,0).
  - Exactly 12 windows after the restart.
- rst pulsed during FLUSH: the next cycle has out_valid = 0, busy = 0 and in_ready = 1, and no further windows are emitted.

Source files
------------

// File: rtl/stream_window_pkg.sv
// stream_window_pkg: shared types and helpers for the stream window generator
package stream_window_pkg;
  localparam int MAX_WIN = 5;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  function automatic int tap_lsb(input int r, c, win, dw);
    return (r * win + c) * dw;
  endfunction
  function automatic int clamp_idx(input int base, off, limit);
    int v = base + off;
    return v < 0 ? 0 : (v >= limit ? limit - 1 : v);
  endfunction
endpackage

// File: rtl/stream_window_gen_line_delay_ram.sv
// line_delay_ram: circular row delay of DEPTH advances (DEPTH-1 entries plus output register)
// Ports: clk, rst (sync, active high), adv (shift one beat), wr_data in, rd_data = beat written DEPTH advances earlier.
module line_delay_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  localparam int N  = DEPTH - 1;
  localparam int AW = $clog2(N);
  logic [DATA_W-1:0] mem_q [N];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  always_comb begin
    ptr_d = adv ? (ptr_q == AW'(N - 1) ? '0 : ptr_q + AW'(1)) : ptr_q;
    rd_d = adv ? mem_q[ptr_q] : rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      rd_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) if (adv) mem_q[ptr_q] <= wr_data;
  assign rd_data = rd_q;
endmodule

// File: rtl/stream_window_gen.sv
// stream_window_gen: raster stream to WIN x WIN neighbourhood windows with border handling and flush
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data/in_sof pixel stream;
// out_valid/out_data/out_sof/out_eol/out_eof window pulse (no backpressure); busy while a frame is in flight.
// STREAM_WINDOW_BORDER_ZERO_EN: out-of-image taps read 0 instead of the replicated edge pixel.
module stream_window_gen
  import stream_window_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int WIN    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_sof,
  output logic                      out_valid,
  output logic [WIN*WIN*DATA_W-1:0] out_data,
  output logic                      out_sof,
  output logic                      out_eol,
  output logic                      out_eof,
  output logic                      busy
);
  localparam int R  = (WIN - 1) / 2;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int WB = $clog2(WIN);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_R = XW'(R);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_R = YW'(R);
  if ((WIN != 3 && WIN != 5) || WIN > MAX_WIN) begin : g_bad_win
    $error("stream_window_gen: WIN must be 3 or 5");
  end
  state_t state_q, state_d;
  logic [XW-1:0] ix_q, ix_d, nx_q, nx_d, ox_q, ox_d;
  logic [YW-1:0] iy_q, iy_d, ny_q, ny_d, oy_q, oy_d;
  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] sr_q [WIN][WIN];
  logic [DATA_W-1:0] sr_d [WIN][WIN];
  logic [DATA_W-1:0] row [WIN];
  logic flush, acc, sof_acc, push, emit;
  assign flush = state_q == FLUSH;
  assign in_ready = !flush;
  assign acc = in_valid && in_ready;
  assign sof_acc = acc && in_sof;
  assign push = flush || (acc && (in_sof || state_q == RUN));
  // window j = k - (R*IMG_W + R) exists once the input reaches row R, column R
  assign emit = push && !sof_acc && (flush || iy_q > Y_R || (iy_q == Y_R && ix_q >= X_R));
  assign row[0] = flush ? '0 : in_data;
  for (genvar g = 1; g < WIN; g++) begin : g_row
    line_delay_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_ram (
      .clk(clk), .rst(rst), .adv(push), .wr_data(row[g-1]), .rd_data(row[g])
    );
  end
  always_comb begin
    state_d = state_q;
    ix_d = ix_q;
    iy_d = iy_q;
    nx_d = nx_q;
    ny_d = ny_q;
    ox_d = ox_q;
    oy_d = oy_q;
    sr_d = sr_q;
    out_valid_d = emit;
    if (push)
      for (int d = 0; d < WIN; d++) begin
        sr_d[d][0] = row[d];
        for (int i = 1; i < WIN; i++) sr_d[d][i] = sr_q[d][i-1];
      end
    if (emit) begin
      ox_d = nx_q;
      oy_d = ny_q;
      nx_d = nx_q == X_LAST ? '0 : nx_q + XW'(1);
      ny_d = nx_q != X_LAST ? ny_q : (ny_q == Y_LAST ? '0 : ny_q + YW'(1));
    end
    if (push && !flush) begin
      ix_d = ix_q == X_LAST ? '0 : ix_q + XW'(1);
      iy_d = ix_q != X_LAST ? iy_q : (iy_q == Y_LAST ? '0 : iy_q + YW'(1));
    end
    if (sof_acc) begin
      state_d = RUN;
      ix_d = XW'(1);
      iy_d = '0;
      nx_d = '0;
      ny_d = '0;
    end else if (push && !flush && ix_q == X_LAST && iy_q == Y_LAST)
      state_d = FLUSH;
    else if (flush && nx_q == X_LAST && ny_q == Y_LAST)
      state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ix_q <= '0;
      iy_q <= '0;
      nx_q <= '0;
      ny_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ix_q <= ix_d;
      iy_q <= iy_d;
      nx_q <= nx_d;
      ny_q <= ny_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      out_valid_q <= out_valid_d;
    end
  end
  always_ff @(posedge clk) sr_q <= sr_d;
  // sr_q[d][i] holds pixel k - d*IMG_W - i; clamping the tap coordinate picks a nearer register
  for (genvar r = 0; r < WIN; r++) begin : g_r
    for (genvar c = 0; c < WIN; c++) begin : g_c
      logic [DATA_W-1:0] t;
      int ry, cx;
      always_comb begin
        ry = clamp_idx(int'(oy_q), r - R, IMG_H);
        cx = clamp_idx(int'(ox_q), c - R, IMG_W);
        t = sr_q[WB'(R + int'(oy_q) - ry)][WB'(R + int'(ox_q) - cx)];
`ifdef STREAM_WINDOW_BORDER_ZERO_EN
        if (ry != int'(oy_q) + r - R || cx != int'(ox_q) + c - R) t = '0;
`endif
      end
      assign out_data[tap_lsb(r, c, WIN, DATA_W) +: DATA_W] = out_valid_q ? t : '0;
    end
  end
  assign out_valid = out_valid_q;
  assign out_sof = out_valid_q && ox_q == '0 && oy_q == '0;
  assign out_eol = out_valid_q && ox_q == X_LAST;
  assign out_eof = out_eol && oy_q == Y_LAST;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_stream_window_gen.sv
// tb_stream_window_gen: scoreboard bench for a 4x3 WIN=3 and an 8x6 WIN=5 instance
module tb_stream_window_gen;
  typedef struct {
    logic [199:0] d;
    logic [2:0]   f;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid_a = 0, in_ready_a, in_sof_a = 0, out_valid_a, out_sof_a, out_eol_a, out_eof_a, busy_a;
  logic [7:0] in_data_a = 0;
  logic [71:0] out_data_a;
  logic in_valid_b = 0, in_ready_b, in_sof_b = 0, out_valid_b, out_sof_b, out_eol_b, out_eof_b, busy_b;
  logic [7:0] in_data_b = 0;
  logic [199:0] out_data_b;
  int total = 0, passed = 0, na = 0, nb = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;

  stream_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .WIN(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .in_sof(in_sof_a), .out_valid(out_valid_a), .out_data(out_data_a), .out_sof(out_sof_a),
    .out_eol(out_eol_a), .out_eof(out_eof_a), .busy(busy_a)
  );
  stream_window_gen #(.DATA_W(8), .IMG_W(8), .IMG_H(6), .WIN(5)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .in_sof(in_sof_b), .out_valid(out_valid_b), .out_data(out_data_b), .out_sof(out_sof_b),
    .out_eol(out_eol_b), .out_eof(out_eof_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] model(input int w, h, win, base, j);
    int rr = (win - 1) / 2, cx = j % w, cy = j / w, x, y, v;
    logic [199:0] res = '0;
    for (int r = 0; r < win; r++)
      for (int c = 0; c < win; c++) begin
        x = cx + c - rr;
        y = cy + r - rr;
        v = base + (y < 0 ? 0 : (y >= h ? h - 1 : y)) * w + (x < 0 ? 0 : (x >= w ? w - 1 : x));
`ifdef STREAM_WINDOW_BORDER_ZERO_EN
        if (x < 0 || x >= w || y < 0 || y >= h) v = 0;
`endif
        res[(r * win + c) * 8 +: 8] = v[7:0];
      end
    return res;
  endfunction

  function automatic logic [199:0] w9(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
    return 200'({t8[7:0], t7[7:0], t6[7:0], t5[7:0], t4[7:0], t3[7:0], t2[7:0], t1[7:0], t0[7:0]});
  endfunction

  task automatic add_a(input int j, input logic [199:0] d);
    exp_t e;
    e.d = d;
    e.f = {j == 0, j % 4 == 3, j == 11};
    qa.push_back(e);
  endtask

  task automatic add_b(input int j);
    exp_t e;
    e.d = model(8, 6, 5, 0, j);
    e.f = {j == 0, j % 8 == 7, j == 47};
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (out_valid_a) begin
      na++;
      chk("a_window_expected", 200'(qa.size() != 0), 200'(1));
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_taps", 200'(out_data_a), ea.d);
        chk("a_flags", 200'({out_sof_a, out_eol_a, out_eof_a}), 200'(ea.f));
      end
    end
    if (out_valid_b) begin
      nb++;
      chk("b_window_expected", 200'(qb.size() != 0), 200'(1));
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        chk("b_taps", out_data_b, eb.d);
        chk("b_flags", 200'({out_sof_b, out_eol_b, out_eof_b}), 200'(eb.f));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("a_reset_ctrl", 200'({in_ready_a, out_valid_a, out_sof_a, out_eol_a, out_eof_a, busy_a}), 200'(6'b100000));
    chk("a_reset_data", 200'(out_data_a), 200'(0));
    chk("b_reset_ctrl", 200'({in_ready_b, out_valid_b, out_sof_b, out_eol_b, out_eof_b, busy_b}), 200'(6'b100000));
    rst = 1'b0;
    in_valid_a = 1;
    in_data_a = 8'd99;
    tick();
    chk("a_idle_drop", 200'({out_valid_a, busy_a}), 200'(0));
    for (int j = 0; j < 12; j++)
      if (j == 0)
`ifdef STREAM_WINDOW_BORDER_ZERO_EN
        add_a(j, w9(0, 0, 0, 0, 0, 1, 0, 4, 5));
`else
        add_a(j, w9(0, 0, 1, 0, 0, 1, 4, 4, 5));
`endif
      else if (j == 5) add_a(j, w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      else if (j == 11)
`ifdef STREAM_WINDOW_BORDER_ZERO_EN
        add_a(j, w9(6, 7, 0, 10, 11, 0, 0, 0, 0));
`else
        add_a(j, w9(6, 7, 7, 10, 11, 11, 10, 11, 11));
`endif
      else add_a(j, model(4, 3, 3, 0, j));
    for (int k = 0; k < 12; k++) begin
      in_valid_a = 1;
      in_sof_a = k == 0;
      in_data_a = 8'(k);
      tick();
      chk("a_valid_timing", 200'(out_valid_a), 200'(k >= 5));
    end
    in_valid_a = 0;
    in_sof_a = 0;
    for (int i = 0; i < 5; i++) begin
      chk("a_flush_ready_low", 200'(in_ready_a), 200'(0));
      tick();
    end
    chk("a_ready_after_flush", 200'({in_ready_a, out_valid_a, out_eof_a, busy_a}), 200'(4'b1110));
    repeat (3) tick();
    chk("a_frame_window_count", 200'(na), 200'(12));
    for (int j = 0; j < 48; j++) add_b(j);
    for (int k = 0; k < 48; k++) begin
      in_valid_b = 1;
      in_sof_b = k == 0;
      in_data_b = 8'(k);
      tick();
      chk("b_valid_after_beat", 200'(out_valid_b), 200'(k >= 18));
      in_valid_b = 0;
      in_sof_b = 0;
      in_data_b = 8'hEE;
      tick();
      if (k < 47) chk("b_gap_no_valid", 200'(out_valid_b), 200'(0));
    end
    for (int i = 0; i < 40 && !in_ready_b; i++) tick();
    chk("b_ready_after_flush", 200'(in_ready_b), 200'(1));
    repeat (3) tick();
    chk("b_window_count", 200'(nb), 200'(48));
    add_a(0, model(4, 3, 3, 0, 0));
    add_a(1, model(4, 3, 3, 0, 1));
    for (int j = 0; j < 12; j++) add_a(j, model(4, 3, 3, 100, j));
    for (int k = 0; k < 7; k++) begin
      in_valid_a = 1;
      in_sof_a = k == 0;
      in_data_a = 8'(k);
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      in_sof_a = k == 0;
      in_data_a = 8'(100 + k);
      tick();
      chk("a_restart_valid", 200'(out_valid_a), 200'(k >= 5));
    end
    in_valid_a = 0;
    in_sof_a = 0;
    for (int i = 0; i < 20 && !in_ready_a; i++) tick();
    chk("a_restart_ready", 200'(in_ready_a), 200'(1));
    repeat (3) tick();
    chk("a_restart_window_count", 200'(na), 200'(26));
    for (int j = 0; j < 8; j++) add_a(j, model(4, 3, 3, 50, j));
    for (int k = 0; k < 12; k++) begin
      in_valid_a = 1;
      in_sof_a = k == 0;
      in_data_a = 8'(50 + k);
      tick();
    end
    in_valid_a = 0;
    in_sof_a = 0;
    tick();
    rst = 1'b1;
    tick();
    chk("a_reset_in_flush", 200'({out_valid_a, busy_a, in_ready_a}), 200'(3'b001));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("a_quiet_after_reset", 200'(out_valid_a), 200'(0));
    end
    chk("a_queue_drained", 200'(qa.size()), 200'(0));
    chk("b_queue_drained", 200'(qb.size()), 200'(0));
    chk("a_total_windows", 200'(na), 200'(34));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
